// File: rtl/video_pkg.sv
// Shared video-subsystem definitions: PLL sequencer states, default cycle counts,
// and the sizing helper for the sequencer's shared phase counter.
package video_pkg;

  typedef enum logic [2:0] {
    PLLSEQ_RESET_HOLD = 3'd0,
    PLLSEQ_WAIT_LOCK  = 3'd1,
    PLLSEQ_SETTLE     = 3'd2,
    PLLSEQ_RUN        = 3'd3,
    PLLSEQ_FAIL       = 3'd4
  } pllseq_state_t;

  localparam int unsigned PLLSEQ_RST_CYCLES    = 16;
  localparam int unsigned PLLSEQ_LOCK_TIMEOUT  = 50000;
  localparam int unsigned PLLSEQ_SETTLE_CYCLES = 1024;
  localparam int unsigned PLLSEQ_RETRY_CNT_W   = 8;

  // Counter holds (count - 1), so clog2 of the largest count is enough.
  function automatic int unsigned pllseq_cnt_w(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, async active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Pixel-clock PLL reset/lock sequencer: hold, wait for lock, settle, release video reset.
// Optional retry limit with a terminal FAIL state under PLLSEQ_RETRY_LIMIT_EN.
module pll_lock_sequencer
  import video_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = PLLSEQ_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = PLLSEQ_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = PLLSEQ_SETTLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = 7
) (
  input  logic                          refclk,
  input  logic                          rst,
  input  logic                          pll_locked,
  input  logic                          relock_req,
  input  logic                          clr_status,
  output logic                          pll_rst,
  output logic                          video_rst_n,
  output logic                          ready,
  output logic                          lock_lost,
  output logic [PLLSEQ_RETRY_CNT_W-1:0] retry_cnt,
  output logic                          fail
);

  localparam int unsigned CNT_W = pllseq_cnt_w(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);

  if (RST_CYCLES == 0 || LOCK_TIMEOUT == 0 || SETTLE_CYCLES == 0 ||
      MAX_RETRIES == 0 || MAX_RETRIES > 255) begin : g_bad_param
    $error("pll_lock_sequencer: cycle counts must be >= 1 and MAX_RETRIES in 1..255");
  end

  pllseq_state_t                 state, state_nxt;
  logic [CNT_W-1:0]              cnt, cnt_nxt;
  logic                          lock_s;
  logic                          lock_lost_nxt;
  logic [PLLSEQ_RETRY_CNT_W-1:0] retry_nxt, retry_inc;
  logic                          timeout_ev, drop_ev;
  logic                          pll_rst_d, video_rst_n_d, ready_d;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // State, shared counter, sticky status and registered outputs.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state       <= PLLSEQ_RESET_HOLD;
      cnt         <= RST_LOAD;
      lock_lost   <= 1'b0;
      retry_cnt   <= '0;
      pll_rst     <= 1'b1;
      video_rst_n <= 1'b0;
      ready       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      lock_lost   <= lock_lost_nxt;
      retry_cnt   <= retry_nxt;
      pll_rst     <= pll_rst_d;
      video_rst_n <= video_rst_n_d;
      ready       <= ready_d;
    end
  end

  // Next state and counter; relock_req preempts everything outside FAIL.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    timeout_ev = 1'b0;
    drop_ev    = 1'b0;
    retry_inc  = (retry_cnt == '1) ? retry_cnt : retry_cnt + PLLSEQ_RETRY_CNT_W'(1);

    case (state)
      PLLSEQ_RESET_HOLD: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == '0) begin
          state_nxt = PLLSEQ_WAIT_LOCK;
          cnt_nxt   = TIMEOUT_LOAD;
        end
      end
      PLLSEQ_WAIT_LOCK: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (lock_s) begin
          state_nxt = PLLSEQ_SETTLE;
          cnt_nxt   = SETTLE_LOAD;
        end else if (cnt == '0) begin
          timeout_ev = !relock_req;
          state_nxt  = PLLSEQ_RESET_HOLD;
          cnt_nxt    = RST_LOAD;
`ifdef PLLSEQ_RETRY_LIMIT_EN
          if (32'(retry_inc) >= MAX_RETRIES) state_nxt = PLLSEQ_FAIL;
`endif
        end
      end
      PLLSEQ_SETTLE: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (!lock_s) begin
          state_nxt = PLLSEQ_WAIT_LOCK;
          cnt_nxt   = TIMEOUT_LOAD;
        end else if (cnt == '0) begin
          state_nxt = PLLSEQ_RUN;
        end
      end
      PLLSEQ_RUN: begin
        if (!lock_s) begin
          drop_ev   = 1'b1;
          state_nxt = PLLSEQ_RESET_HOLD;
          cnt_nxt   = RST_LOAD;
        end
      end
`ifdef PLLSEQ_RETRY_LIMIT_EN
      PLLSEQ_FAIL: begin
        if (clr_status) begin
          state_nxt = PLLSEQ_RESET_HOLD;
          cnt_nxt   = RST_LOAD;
        end
      end
`endif
      default: begin
        state_nxt = PLLSEQ_RESET_HOLD;
        cnt_nxt   = RST_LOAD;
      end
    endcase

    if (relock_req && state != PLLSEQ_FAIL) begin
      state_nxt = PLLSEQ_RESET_HOLD;
      cnt_nxt   = RST_LOAD;
    end

    // Set events take priority over clr_status.
    lock_lost_nxt = drop_ev ? 1'b1 : (clr_status ? 1'b0 : lock_lost);
    retry_nxt     = timeout_ev ? retry_inc : (clr_status ? '0 : retry_cnt);
  end

  // Output decode from the next state so outputs change with the state register.
  always_comb begin
    pll_rst_d     = 1'b0;
    video_rst_n_d = 1'b0;
    ready_d       = 1'b0;
    case (state_nxt)
      PLLSEQ_RESET_HOLD: pll_rst_d = 1'b1;
      PLLSEQ_RUN: begin
        video_rst_n_d = 1'b1;
        ready_d       = 1'b1;
      end
      PLLSEQ_FAIL:       pll_rst_d = 1'b1;
      default: ;
    endcase
  end

`ifdef PLLSEQ_RETRY_LIMIT_EN
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) fail <= 1'b0;
    else      fail <= (state_nxt == PLLSEQ_FAIL);
  end
`else
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with a shortened lock timeout.
module tb_pll_lock_sequencer;
  import video_pkg::*;

  localparam int unsigned TB_RST     = 16;
  localparam int unsigned TB_TIMEOUT = 400;
  localparam int unsigned TB_SETTLE  = 1024;
  localparam int unsigned TB_MAXR    = 7;
`ifdef PLLSEQ_RETRY_LIMIT_EN
  localparam int N_TIMEOUTS = 7;
`else
  localparam int N_TIMEOUTS = 8;
`endif

  localparam int S_PLL = 0;
  localparam int S_VRN = 1;
  localparam int S_RDY = 2;

  logic       refclk     = 1'b0;
  logic       rst        = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       clr_status = 1'b0;
  logic       pll_rst, video_rst_n, ready, lock_lost, fail;
  logic [7:0] retry_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int n;

  pll_lock_sequencer #(
    .RST_CYCLES    (TB_RST),
    .LOCK_TIMEOUT  (TB_TIMEOUT),
    .SETTLE_CYCLES (TB_SETTLE),
    .MAX_RETRIES   (TB_MAXR)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .relock_req  (relock_req),
    .clr_status  (clr_status),
    .pll_rst     (pll_rst),
    .video_rst_n (video_rst_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .retry_cnt   (retry_cnt),
    .fail        (fail)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      S_PLL:   return pll_rst;
      S_VRN:   return video_rst_n;
      default: return ready;
    endcase
  endfunction

  // Ticks until the selected output reaches lvl; returns ticks taken (limit on expiry).
  task automatic wait_level(input int sel, input logic lvl, input int limit, output int cnt);
    cnt = 0;
    while (sig(sel) != lvl && cnt < limit) begin
      tick();
      cnt++;
    end
  endtask

  task automatic pulse_relock();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_pll_rst",     int'(pll_rst),     1);
    chk("rst_video_rst_n", int'(video_rst_n), 0);
    chk("rst_ready",       int'(ready),       0);
    chk("rst_lock_lost",   int'(lock_lost),   0);
    chk("rst_retry_cnt",   int'(retry_cnt),   0);
    chk("rst_fail",        int'(fail),        0);

    // Power-up: hold, lock 100 cycles after pll_rst falls, settle, release.
    rst = 1'b1;
    wait_level(S_PLL, 1'b0, 100, n);
    chk("hold_len", n, 16);
    chk("hold_vrn", int'(video_rst_n), 0);
    repeat (100) tick();
    pll_locked = 1'b1;
    wait_level(S_RDY, 1'b1, 2000, n);
    chk("lock_to_ready", n, 3 + 1024);
    chk("run_vrn",     int'(video_rst_n), 1);
    chk("run_pll_rst", int'(pll_rst),     0);
    chk("run_retry",   int'(retry_cnt),   0);

    // Software relock from RUN.
    pulse_relock();
    chk("relock_pll_rst", int'(pll_rst),     1);
    chk("relock_ready",   int'(ready),       0);
    chk("relock_vrn",     int'(video_rst_n), 0);
    wait_level(S_RDY, 1'b1, 2000, n);
    chk("relock_to_ready", n, 16 + 1 + 1024);
    chk("relock_lost",     int'(lock_lost), 0);

    // One-cycle lock glitch 500 cycles into SETTLE restarts the settle window.
    pulse_relock();
    repeat (517) tick();
    chk("glitch_pre_ready", int'(ready), 0);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_level(S_RDY, 1'b1, 2000, n);
    chk("glitch_to_ready", n + 1, 1028);
    chk("glitch_retry",    int'(retry_cnt), 0);
    chk("glitch_lost",     int'(lock_lost), 0);

    // Lock drop in RUN.
    pll_locked = 1'b0;
    wait_level(S_VRN, 1'b0, 20, n);
    chk("drop_latency", n, 3);
    chk("drop_pll_rst", int'(pll_rst),   1);
    chk("drop_lost",    int'(lock_lost), 1);
    chk("drop_ready",   int'(ready),     0);
    pulse_clr();
    chk("clr_lost", int'(lock_lost), 0);
    pll_locked = 1'b1;
    wait_level(S_RDY, 1'b1, 2000, n);
    chk("drop_to_ready", n, 1040);
    chk("drop_retry",    int'(retry_cnt), 0);

    // Drop, relock and clr in the same cycle: relock path taken, lock_lost still set.
    pll_locked = 1'b0;
    tick();
    tick();
    relock_req = 1'b1;
    clr_status = 1'b1;
    tick();
    relock_req = 1'b0;
    clr_status = 1'b0;
    chk("combo_vrn",  int'(video_rst_n), 0);
    chk("combo_lost", int'(lock_lost),   1);
    wait_level(S_PLL, 1'b0, 100, n);
    chk("combo_hold_len", n, 16);
    pulse_clr();
    chk("combo_clr_lost", int'(lock_lost), 0);

    // Lock never arrives: repeated timeouts.
    pulse_relock();
    for (int i = 1; i <= N_TIMEOUTS; i++) begin
      wait_level(S_PLL, 1'b0, 100, n);
      chk("retry_hold_len", n, 16);
      wait_level(S_PLL, 1'b1, 1000, n);
      chk("timeout_len", n, 400);
      chk("timeout_retry_cnt", int'(retry_cnt), i);
`ifdef PLLSEQ_RETRY_LIMIT_EN
      chk("timeout_fail", int'(fail), (i == N_TIMEOUTS) ? 1 : 0);
`else
      chk("timeout_fail", int'(fail), 0);
`endif
    end

`ifdef PLLSEQ_RETRY_LIMIT_EN
    repeat (600) tick();
    chk("fail_sticky",   int'(fail),      1);
    chk("fail_pll_rst",  int'(pll_rst),   1);
    chk("fail_vrn",      int'(video_rst_n), 0);
    chk("fail_retry",    int'(retry_cnt), 7);
    pulse_relock();
    chk("fail_ignores_relock", int'(fail), 1);
`endif
    pulse_clr();
    chk("clr_retry",   int'(retry_cnt), 0);
    chk("clr_fail",    int'(fail),      0);
    chk("clr_pll_rst", int'(pll_rst),   1);
    wait_level(S_PLL, 1'b0, 100, n);
    wait_level(S_PLL, 1'b1, 1000, n);
    chk("retry_after_clr", int'(retry_cnt), 1);

    // Reset asserted mid-SETTLE.
    pll_locked = 1'b1;
    wait_level(S_PLL, 1'b0, 100, n);
    repeat (303) tick();
    chk("mid_settle_pll_rst", int'(pll_rst), 0);
    chk("mid_settle_ready",   int'(ready),   0);
    rst = 1'b0;
    #1;
    chk("async_pll_rst", int'(pll_rst),     1);
    chk("async_vrn",     int'(video_rst_n), 0);
    chk("async_ready",   int'(ready),       0);
    chk("async_lost",    int'(lock_lost),   0);
    chk("async_retry",   int'(retry_cnt),   0);
    chk("async_fail",    int'(fail),        0);
    tick();
    tick();
    rst = 1'b1;
    wait_level(S_PLL, 1'b0, 100, n);
    chk("restart_hold_len", n, 16);
    wait_level(S_RDY, 1'b1, 2000, n);
    chk("restart_to_ready", n, 1 + 1024);
    chk("restart_vrn",      int'(video_rst_n), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Controls the reset and lock sequence of the video pixel-clock PLL (50 MHz reference, 25.175 MHz pixel clock). The block holds the PLL in reset for a fixed time and waits for lock with a timeout. It requires lock to stay stable before releasing the video-pipeline reset, and it re-sequences the PLL when lock is lost or software requests it. It runs in the reference-clock domain, between the board reset and the PLL plus video timing logic.

## Interface
- `RST_CYCLES`, 16: number of refclk cycles that `pll_rst` is held high per attempt.
- `LOCK_TIMEOUT`, 50000: refclk cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- `SETTLE_CYCLES`, 1024: refclk cycles of continuous synchronized lock required before release.
- `MAX_RETRIES`, 7: retry limit, used only with `PLLSEQ_RETRY_LIMIT_EN`.
- `refclk` input 1: 50 MHz reference clock, the only clock.
- `rst` input 1: asynchronous, active-low reset.
- `pll_locked` input 1: PLL `locked`, asynchronous to refclk.
- `relock_req` input 1: single-cycle pulse that forces a new PLL sequence.
- `clr_status` input 1: single-cycle pulse that clears the sticky flags.
- `pll_rst` output 1: drives the PLL `rst`, active-high.
- `video_rst_n` output 1: active-low reset for the pixel-domain logic (the consumer synchronizes it).
- `ready` output 1: high in RUN.
- `lock_lost` output 1: sticky, set on any lock drop while in RUN.
- `retry_cnt` output 8: number of timeout retries since the last `clr_status`, saturating at 255.
- `fail` output 1: high in FAIL (only with the macro; otherwise tied to 0).

## Operation
- `pll_locked` passes through a 2-flop synchronizer; `lock_s` below means the synchronized value.
- States are RESET_HOLD, WAIT_LOCK, SETTLE, RUN and FAIL. All transitions are registered, and one shared down-counter is reloaded on each state entry.
- RESET_HOLD:
  - `pll_rst`=1.
  - After `RST_CYCLES` cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst`=0.
  - If `lock_s`=1, go to SETTLE.
  - If the counter expires with no lock, increment `retry_cnt` (saturating) and go to RESET_HOLD.
- SETTLE:
  - If `lock_s`=0, return to WAIT_LOCK with the timeout counter reloaded; this is not counted as a retry.
  - After `SETTLE_CYCLES` consecutive locked cycles, go to RUN.
- RUN:
  - `video_rst_n`=1 and `ready`=1.
  - If `lock_s`=0, set `lock_lost` and go to RESET_HOLD.
- `relock_req` in any state except FAIL goes to RESET_HOLD; it does not set `lock_lost` or `retry_cnt`.
- In every state except RUN, `video_rst_n`=0 and `ready`=0.
- Simultaneous events:
  - `relock_req` together with a lock drop in RUN: go to RESET_HOLD and set `lock_lost`.
  - `clr_status` together with a set event: the set wins.
- Counter width is `$clog2` of the largest of the three cycle parameters. Each phase lasts exactly its parameter count.

## Timing
- Reset values:
  - `pll_rst`=1, `video_rst_n`=0, `ready`=0, `lock_lost`=0, `retry_cnt`=0, `fail`=0.
  - State is RESET_HOLD with the counter loaded.
- After `rst` deasserts, `pll_rst` stays high for exactly `RST_CYCLES` refclk cycles.
- Lock latency: 2 cycles of synchronizer, then 1 cycle to register the transition.
- Release: `video_rst_n` and `ready` rise together, `SETTLE_CYCLES` cycles after SETTLE entry.
- Lock drop in RUN: `video_rst_n` falls 3 cycles after `pll_locked` falls (2 sync + 1 register). `pll_rst` rises in the same cycle.
- `rst` asserted at any point, including mid-settle, returns every output to its reset value immediately (asynchronously).

## Configuration
- `PLLSEQ_RETRY_LIMIT_EN` defined:
  - When `retry_cnt` reaches `MAX_RETRIES` on a timeout, go to FAIL instead of RESET_HOLD.
  - In FAIL: `pll_rst`=1, `video_rst_n`=0, `fail`=1.
  - Only `rst` or `clr_status` leaves FAIL. `clr_status` returns to RESET_HOLD with `retry_cnt`=0.
- `PLLSEQ_RETRY_LIMIT_EN` undefined:
  - Retries continue indefinitely and the FAIL state does not exist.
  - `fail` is tied to 0.

## Structure
- Shared package `video_pkg` holds:
  - the state enum `pllseq_state_t`;
  - the default cycle constants (`PLLSEQ_RST_CYCLES`, `PLLSEQ_LOCK_TIMEOUT`, `PLLSEQ_SETTLE_CYCLES`);
  - the `retry_cnt` width constant.
- One sub-module, `sync_2ff`: a 1-bit two-flop synchronizer with async active-low reset to 0, reused by other CDC points.

## Test plan
- Reset release, lock asserted 100 cycles after `pll_rst` falls, held high → `pll_rst` high for 16 cycles; `video_rst_n` rises 1024 cycles after SETTLE entry.
- Lock never asserts → after 50000 cycles in WAIT_LOCK, `pll_rst` pulses for 16 cycles, `retry_cnt`=1, and this repeats. With the macro, `fail`=1 after 7 timeouts; `clr_status` gives `retry_cnt`=0 and a new sequence.
- Lock glitches low for 1 cycle during SETTLE at cycle 500 → back to WAIT_LOCK, settle restarts from 1024, `retry_cnt` unchanged.
- Lock drops in RUN → `video_rst_n`=0 3 cycles later, `lock_lost`=1, full resequence; `clr_status` clears `lock_lost`.
- `relock_req` pulse in RUN → RESET_HOLD next cycle, `lock_lost` stays 0, `ready` is back after 16 + lock + 1024 cycles.
- `rst` asserted mid-SETTLE → all outputs at reset values at once; the sequence restarts cleanly from RESET_HOLD.
